// File: rtl/tinyqv_instr_prefetch.sv
// Instruction prefetch: assembles the memory controller's byte stream into a halfword FIFO.
// Define TINYQV_PREFETCH_LEN_DECODE_EN to derive instruction length from the head halfword.
module tinyqv_instr_prefetch #(
  parameter int          DEPTH      = 4,
  parameter logic [22:0] RESET_ADDR = 23'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_load,
  input  logic [22:0] new_pc,
  input  logic        instr_taken,
  input  logic        instr_len,
  output logic [31:0] instr_out,
  output logic        instr_valid_16,
  output logic        instr_valid_32,
`ifdef TINYQV_PREFETCH_LEN_DECODE_EN
  output logic        instr_complete,
`endif
  output logic [22:0] instr_addr,
  output logic        instr_fetch_restart,
  output logic        instr_fetch_stall,
  input  logic        instr_fetch_started,
  input  logic        instr_fetch_stopped,
  input  logic [7:0]  instr_data,
  input  logic        instr_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RESTART, STREAM} state_t;

  state_t         state, state_nxt;
  logic           restart_pending;
  logic [22:0]    fetch_addr;
  logic [7:0]     low_byte;
  logic           low_held;
  logic [15:0]    mem [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count;

  logic           has1, has2, len32, pop, byte_ok, commit;
  logic [CW-1:0]  pop_n;

  assign has1 = (count != '0);
  assign has2 = (count >= CW'(2));

`ifdef TINYQV_PREFETCH_LEN_DECODE_EN
  assign len32          = (mem[rd_ptr][1:0] == 2'b11);
  assign instr_complete = len32 ? has2 : has1;
`else
  assign len32 = instr_len;
`endif

  assign pop   = instr_taken && !pc_load && (len32 ? has2 : has1);
  assign pop_n = pop ? (len32 ? CW'(2) : CW'(1)) : '0;

  // Bytes are only meaningful inside a stream we requested; anything else is stale.
  assign byte_ok = instr_ready && !pc_load &&
                   ((state == STREAM && !instr_fetch_stopped) ||
                    (state == RESTART && instr_fetch_started));
  assign commit  = byte_ok && low_held && (count != FULL);

  assign instr_valid_16    = has1;
  assign instr_valid_32    = has2;
  assign instr_out         = {has2 ? mem[rd_ptr + PW'(1)] : 16'h0, has1 ? mem[rd_ptr] : 16'h0};
  assign instr_addr        = fetch_addr;
  assign instr_fetch_stall = (count == FULL) || (count == FULL - CW'(1) && low_held);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RESTART;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (restart_pending && count != FULL) state_nxt = RESTART;
      RESTART: if (instr_fetch_started) state_nxt = STREAM;
      STREAM:  if (instr_fetch_stopped) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (pc_load) state_nxt = RESTART;
  end

  always_comb begin
    instr_fetch_restart = (state == RESTART);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count           <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      low_held        <= 1'b0;
      low_byte        <= 8'h0;
      fetch_addr      <= RESET_ADDR;
      restart_pending <= 1'b1;
    end else if (pc_load) begin
      count           <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      low_held        <= 1'b0;
      fetch_addr      <= new_pc;
      restart_pending <= 1'b1;
    end else begin
      count <= count - pop_n + CW'(commit);
      if (pop) rd_ptr <= rd_ptr + (len32 ? PW'(2) : PW'(1));
      if (byte_ok) begin
        if (!low_held) begin
          low_byte <= instr_data;
          low_held <= 1'b1;
        end else if (count != FULL) begin
          wr_ptr     <= wr_ptr + PW'(1);
          fetch_addr <= fetch_addr + 23'd1;
          low_held   <= 1'b0;
        end
      end
      // Preempted mid-halfword: drop the partial byte, fetch_addr still points at it.
      if (state == STREAM && instr_fetch_stopped) begin
        low_held        <= 1'b0;
        restart_pending <= 1'b1;
      end
      if (state == RESTART && instr_fetch_started) restart_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) mem[wr_ptr] <= {instr_data, low_byte};
  end

endmodule

// File: tb/tb_tinyqv_instr_prefetch.sv
// Bench for tinyqv_instr_prefetch: directed protocol cases, then a random memory
// controller / decoder with a program-order scoreboard of expected halfwords.
module tb_tinyqv_instr_prefetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        pc_load;
  logic [22:0] new_pc;
  logic        instr_taken;
  logic        instr_len;
  logic [31:0] instr_out;
  logic        instr_valid_16;
  logic        instr_valid_32;
  logic [22:0] instr_addr;
  logic        instr_fetch_restart;
  logic        instr_fetch_stall;
  logic        instr_fetch_started;
  logic        instr_fetch_stopped;
  logic [7:0]  instr_data;
  logic        instr_ready;

  int checks = 0;
  int fails  = 0;
  int consumed = 0;

  tinyqv_instr_prefetch #(.DEPTH(4), .RESET_ADDR(23'h000000)) dut (
    .clk(clk), .rst(rst), .pc_load(pc_load), .new_pc(new_pc),
    .instr_taken(instr_taken), .instr_len(instr_len), .instr_out(instr_out),
    .instr_valid_16(instr_valid_16), .instr_valid_32(instr_valid_32),
    .instr_addr(instr_addr), .instr_fetch_restart(instr_fetch_restart),
    .instr_fetch_stall(instr_fetch_stall), .instr_fetch_started(instr_fetch_started),
    .instr_fetch_stopped(instr_fetch_stopped), .instr_data(instr_data),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  // Memory image: byte at byte address ba.
  function automatic logic [7:0] mbyte(logic [23:0] ba);
    logic [31:0] t;
    t = {8'h0, ba} * 32'h9E3779B1;
    return t[23:16] ^ ba[7:0];
  endfunction

  function automatic logic [15:0] hw(logic [22:0] a);
    return {mbyte({a, 1'b1}), mbyte({a, 1'b0})};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one full cycle of inputs, then sample just after the edge.
  task automatic cyc(bit st, bit sp, bit rdy, logic [7:0] d, bit tk, bit ln, bit pl, logic [22:0] pc);
    instr_fetch_started = st; instr_fetch_stopped = sp; instr_ready = rdy; instr_data = d;
    instr_taken = tk; instr_len = ln; pc_load = pl; new_pc = pc;
    tick();
  endtask

  task automatic bytein(logic [7:0] d);
    cyc(0, 0, 1, d, 0, 0, 0, 23'h0);
  endtask

  task automatic ctrl_loop(int n);
    int cs = 0;
    int dly = 0;
    logic [23:0] ba = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      instr_fetch_started = 0; instr_fetch_stopped = 0; instr_ready = 0;
      case (cs)
        0: if (instr_fetch_restart) begin dly = $urandom_range(0, 3); cs = 1; end
        1: if (dly > 0) dly--;
           else begin
             instr_fetch_started = 1; ba = {instr_addr, 1'b0}; cs = 2;
             if ($urandom_range(0, 1) == 1) begin instr_ready = 1; instr_data = mbyte(ba); ba++; end
           end
        default:
          if (instr_fetch_restart) begin
            // Redirected under us: maybe spill stale bytes before noticing.
            if ($urandom_range(0, 1) == 1) begin instr_ready = 1; instr_data = 8'($urandom); end
            else cs = 0;
          end else if ($urandom_range(0, 39) == 0) begin
            instr_fetch_stopped = 1; cs = 0;
          end else if (!instr_fetch_stall && $urandom_range(0, 3) != 0) begin
            instr_ready = 1; instr_data = mbyte(ba); ba++;
          end
      endcase
    end
    instr_fetch_started = 0; instr_fetch_stopped = 0; instr_ready = 0;
  endtask

  task automatic dec_loop(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      pc_load = (i == 0) || ($urandom_range(0, 59) == 0);
      if (i == 0) new_pc = 23'h7FFFF8;
      else new_pc = ($urandom_range(0, 1) == 1) ? 23'($urandom) : 23'h7FFFFC + 23'($urandom_range(0, 3));
      instr_taken = 1'($urandom_range(0, 1));
      instr_len   = 1'($urandom_range(0, 1));
    end
    pc_load = 0; instr_taken = 0;
  endtask

  // Scoreboard: program order from the last redirect defines every halfword the decoder sees.
  task automatic mon_loop(int n);
    logic [15:0] q[$];
    logic [22:0] next_a = '0;
    bit synced = 0;
    int k;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (synced) begin
        while (q.size() < 2) begin q.push_back(hw(next_a)); next_a++; end
        if (instr_valid_16) chk("rand_hw0", {16'h0, instr_out[15:0]}, {16'h0, q[0]});
        else                chk("rand_empty_out", instr_out, 32'h0);
        if (instr_valid_32)      chk("rand_hw1", {16'h0, instr_out[31:16]}, {16'h0, q[1]});
        else if (instr_valid_16) chk("rand_hi_zero", {16'h0, instr_out[31:16]}, 32'h0);
        chk("rand_v32_implies_v16", {31'h0, instr_valid_32 & ~instr_valid_16}, 32'h0);
      end
      if (pc_load) begin
        q.delete(); next_a = new_pc; synced = 1;
      end else if (synced && instr_taken) begin
        k = instr_len ? (instr_valid_32 ? 2 : 0) : (instr_valid_16 ? 1 : 0);
        repeat (k) void'(q.pop_front());
        consumed += k;
      end
    end
  endtask

  initial begin
    rst = 1; pc_load = 0; new_pc = 0; instr_taken = 0; instr_len = 0;
    instr_fetch_started = 0; instr_fetch_stopped = 0; instr_data = 0; instr_ready = 0;
    #12;
    chk("reset_valid16", {31'h0, instr_valid_16}, 32'd0);
    chk("reset_valid32", {31'h0, instr_valid_32}, 32'd0);
    chk("reset_out", instr_out, 32'h0);
    chk("reset_stall", {31'h0, instr_fetch_stall}, 32'd0);
    chk("reset_restart", {31'h0, instr_fetch_restart}, 32'd1);
    chk("reset_addr", {9'h0, instr_addr}, 32'h0);
    rst = 0;
    tick();
    chk("restart_held", {31'h0, instr_fetch_restart}, 32'd1);

    // First stream: 13 00 6F 00
    cyc(1, 0, 0, 8'h00, 0, 0, 0, 23'h0);
    chk("restart_drop", {31'h0, instr_fetch_restart}, 32'd0);
    bytein(8'h13);
    chk("half_byte_invalid", {31'h0, instr_valid_16}, 32'd0);
    bytein(8'h00);
    chk("first_hw_out", instr_out, 32'h00000013);
    bytein(8'h6F); bytein(8'h00);
    chk("first_word_out", instr_out, 32'h006F0013);
    chk("first_word_v32", {31'h0, instr_valid_32}, 32'd1);
    chk("first_word_addr", {9'h0, instr_addr}, 32'd2);
    cyc(0, 0, 0, 8'h00, 1, 1, 0, 23'h0);
    chk("take32_empty", {31'h0, instr_valid_16}, 32'd0);

    // Fill to DEPTH, then overflow by two bytes.
    for (int i = 0; i < 8; i++) begin
      bytein(8'h10 + 8'(i));
      if (i == 5) chk("stall_cnt3", {31'h0, instr_fetch_stall}, 32'd0);
      if (i == 6) chk("stall_cnt3_low", {31'h0, instr_fetch_stall}, 32'd1);
    end
    chk("full_stall", {31'h0, instr_fetch_stall}, 32'd1);
    chk("full_out", instr_out, 32'h13121110);
    bytein(8'h18);
    chk("absorb_out", instr_out, 32'h13121110);
    bytein(8'hEE);
    cyc(0, 0, 0, 8'h00, 1, 1, 0, 23'h0);
    chk("pop_second_pair", instr_out, 32'h17161514);
    chk("stall_after_pop", {31'h0, instr_fetch_stall}, 32'd0);
    cyc(0, 0, 1, 8'h19, 1, 1, 0, 23'h0);
    chk("pop_push_same_cycle", instr_out, 32'h00001918);
    chk("pop_push_addr", {9'h0, instr_addr}, 32'd7);

    // Preempt mid-halfword and refetch.
    cyc(0, 0, 1, 8'hAB, 1, 0, 0, 23'h0);
    chk("pop16_empty", {31'h0, instr_valid_16}, 32'd0);
    cyc(0, 1, 0, 8'h00, 0, 0, 0, 23'h0);
    chk("stopped_idle", {31'h0, instr_fetch_restart}, 32'd0);
    cyc(0, 0, 0, 8'h00, 0, 0, 0, 23'h0);
    chk("stopped_restart", {31'h0, instr_fetch_restart}, 32'd1);
    chk("stopped_addr", {9'h0, instr_addr}, 32'd7);
    cyc(1, 0, 1, 8'h34, 0, 0, 0, 23'h0);
    bytein(8'h12);
    chk("refetch_out", instr_out, 32'h00001234);
    chk("refetch_addr", {9'h0, instr_addr}, 32'd8);

    // Redirect with data buffered and a byte in flight.
    bytein(8'h56); bytein(8'h78); bytein(8'h99);
    chk("pre_flush_out", instr_out, 32'h78561234);
    cyc(0, 0, 1, 8'h88, 1, 0, 1, 23'h000100);
    chk("flush_valid", {31'h0, instr_valid_16}, 32'd0);
    chk("flush_restart", {31'h0, instr_fetch_restart}, 32'd1);
    chk("flush_addr", {9'h0, instr_addr}, 32'h100);
    for (int i = 0; i < 3; i++) bytein(8'hEE);
    chk("stale_ignored", {31'h0, instr_valid_16}, 32'd0);
    cyc(1, 0, 1, 8'h01, 0, 0, 0, 23'h0);
    bytein(8'h02);
    chk("redirect_out", instr_out, 32'h00000201);
    chk("redirect_addr", {9'h0, instr_addr}, 32'h101);
    cyc(0, 0, 0, 8'h00, 1, 1, 0, 23'h0);
    chk("take32_ignored", instr_out, 32'h00000201);

    // Address wrap.
    cyc(0, 0, 0, 8'h00, 0, 0, 1, 23'h7FFFFF);
    chk("wrap_pre_addr", {9'h0, instr_addr}, 32'h7FFFFF);
    cyc(1, 0, 1, 8'hAA, 0, 0, 0, 23'h0);
    bytein(8'hBB);
    chk("wrap_addr", {9'h0, instr_addr}, 32'h0);
    chk("wrap_out", instr_out, 32'h0000BBAA);
    cyc(0, 0, 0, 8'h00, 0, 0, 0, 23'h0);

    fork
      ctrl_loop(3000);
      dec_loop(3000);
      mon_loop(3000);
    join
    tick();
    chk("rand_progress", {31'h0, consumed >= 100}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
